vy_hakem: RTL and testbench

//  Two-port arbiter that shares the single veri yolu (vy_denetleyici) request/response channel between the
//  L1 instruction (port 0) and L1 data (port 1) controllers. Sits between both l1_denetleyici vy_* interfaces
//  and vy_denetleyici l1_* interface. Round-robin grant, one outstanding transaction, response routed to owner.

---
 rtl/vy_hakem_pkg.sv | 23 ++
 rtl/vy_hakem_if.sv | 25 ++
 rtl/vy_hakem.sv | 120 ++++++++++++
 tb/tb_vy_hakem.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/vy_hakem_pkg.sv
// vy_hakem_pkg: shared widths, FSM state encoding and port ids for the veri yolu arbiter.
package vy_hakem_pkg;

  localparam int ADRES_BIT = 32;
  localparam int BLOK_BIT  = 128;

  // BOSTA: idle/arbitrating, ISTEK: request held downstream, YANIT: read block returning
  typedef enum logic [1:0] {
    BOSTA = 2'd0,
    ISTEK = 2'd1,
    YANIT = 2'd2
  } durum_e;

  typedef enum logic {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

  function automatic port_e karsi_port(input port_e p);
    return (p == PORT0) ? PORT1 : PORT0;
  endfunction

endpackage

// File: rtl/vy_hakem_if.sv
// vy_hakem_if: one veri yolu request/response channel; the master issues requests and takes read blocks.
interface vy_hakem_if
  import vy_hakem_pkg::*;
();

  logic [ADRES_BIT-1:0] istek_adres;
  logic                 istek_gecerli;
  logic                 istek_yaz;
  logic [BLOK_BIT-1:0]  istek_veri;
  logic                 istek_hazir;
  logic [BLOK_BIT-1:0]  veri;
  logic                 veri_gecerli;
  logic                 veri_hazir;

  modport master (
    output istek_adres, istek_gecerli, istek_yaz, istek_veri, veri_hazir,
    input  istek_hazir, veri, veri_gecerli
  );

  modport slave (
    input  istek_adres, istek_gecerli, istek_yaz, istek_veri, veri_hazir,
    output istek_hazir, veri, veri_gecerli
  );

endinterface

// File: rtl/vy_hakem.sv
// vy_hakem: round-robin arbiter sharing the single veri yolu channel between L1 instruction (port 0)
// and L1 data (port 1); one outstanding transaction, read response routed back to its owner.
module vy_hakem
  import vy_hakem_pkg::*;
(
  input  logic       clk_i,
  input  logic       rst_i,
  vy_hakem_if.slave  p0,
  vy_hakem_if.slave  p1,
  vy_hakem_if.master vy
);

  durum_e r_durum;
  durum_e w_durum_sonraki;
  port_e  r_oncelik;
  port_e  r_sahip;

  logic [ADRES_BIT-1:0] r_adres;
  logic                 r_yaz;
  logic [BLOK_BIT-1:0]  r_veri;

  port_e w_kazanan;
  logic  w_talep;
  logic  w_kabul;
  logic  w_sahip_hazir;

  always_comb begin
    w_kazanan = PORT0;
    w_talep   = p0.istek_gecerli | p1.istek_gecerli;
    if (p0.istek_gecerli && p1.istek_gecerli) begin
      w_kazanan = r_oncelik;
    end else if (p1.istek_gecerli) begin
      w_kazanan = PORT1;
    end
  end

  assign w_kabul       = !rst_i && (r_durum == BOSTA) && w_talep;
  assign w_sahip_hazir = (r_sahip == PORT0) ? p0.veri_hazir : p1.veri_hazir;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_durum <= BOSTA;
    end else begin
      r_durum <= w_durum_sonraki;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      r_oncelik <= PORT0;
      r_sahip   <= PORT0;
      r_adres   <= '0;
      r_yaz     <= 1'b0;
      r_veri    <= '0;
    end else if (w_kabul) begin
      r_sahip   <= w_kazanan;
      r_oncelik <= karsi_port(w_kazanan);
      if (w_kazanan == PORT0) begin
        r_adres <= p0.istek_adres;
        r_yaz   <= p0.istek_yaz;
        r_veri  <= p0.istek_veri;
      end else begin
        r_adres <= p1.istek_adres;
        r_yaz   <= p1.istek_yaz;
        r_veri  <= p1.istek_veri;
      end
    end
  end

  // Outputs are forced low while rst_i is high, even in the cycle before the synchronous reset lands.
  always_comb begin
    w_durum_sonraki  = r_durum;
    p0.istek_hazir   = 1'b0;
    p1.istek_hazir   = 1'b0;
    p0.veri          = '0;
    p0.veri_gecerli  = 1'b0;
    p1.veri          = '0;
    p1.veri_gecerli  = 1'b0;
    vy.istek_adres   = '0;
    vy.istek_gecerli = 1'b0;
    vy.istek_yaz     = 1'b0;
    vy.istek_veri    = '0;
    vy.veri_hazir    = 1'b0;
    if (!rst_i) begin
      case (r_durum)
        BOSTA: begin
          p0.istek_hazir = w_talep && (w_kazanan == PORT0);
          p1.istek_hazir = w_talep && (w_kazanan == PORT1);
          if (w_kabul) begin
            w_durum_sonraki = ISTEK;
          end
        end
        ISTEK: begin
          vy.istek_adres   = r_adres;
          vy.istek_gecerli = 1'b1;
          vy.istek_yaz     = r_yaz;
          vy.istek_veri    = r_veri;
          if (vy.istek_hazir) begin
            w_durum_sonraki = r_yaz ? BOSTA : YANIT;
          end
        end
        YANIT: begin
          vy.veri_hazir = w_sahip_hazir;
          if (r_sahip == PORT0) begin
            p0.veri         = vy.veri;
            p0.veri_gecerli = vy.veri_gecerli;
          end else begin
            p1.veri         = vy.veri;
            p1.veri_gecerli = vy.veri_gecerli;
          end
          if (vy.veri_gecerli && w_sahip_hazir) begin
            w_durum_sonraki = BOSTA;
          end
        end
        default: w_durum_sonraki = BOSTA;
      endcase
    end
  end

endmodule

// File: tb/tb_vy_hakem.sv
// tb_vy_hakem: randomized two-port traffic against a transaction-level model of the arbiter,
// with a scoreboard of expected downstream requests and expected read blocks.
module tb_vy_hakem;
  import vy_hakem_pkg::*;

  typedef struct packed {
    logic [ADRES_BIT-1:0] adres;
    logic                 yaz;
    logic [BLOK_BIT-1:0]  veri;
  } req_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  vy_hakem_if p0_if ();
  vy_hakem_if p1_if ();
  vy_hakem_if vy_if ();

  vy_hakem dut (.clk_i(clk), .rst_i(rst), .p0(p0_if), .p1(p1_if), .vy(vy_if));

  logic [ADRES_BIT-1:0] m_adres [2];
  logic [BLOK_BIT-1:0]  m_veri  [2];
  logic [1:0]           m_gecerli, m_yaz, m_vhazir;
  logic                 d_ihazir, d_vgecerli;
  logic [BLOK_BIT-1:0]  d_veri;

  assign p0_if.istek_adres   = m_adres[0];
  assign p0_if.istek_gecerli = m_gecerli[0];
  assign p0_if.istek_yaz     = m_yaz[0];
  assign p0_if.istek_veri    = m_veri[0];
  assign p0_if.veri_hazir    = m_vhazir[0];
  assign p1_if.istek_adres   = m_adres[1];
  assign p1_if.istek_gecerli = m_gecerli[1];
  assign p1_if.istek_yaz     = m_yaz[1];
  assign p1_if.istek_veri    = m_veri[1];
  assign p1_if.veri_hazir    = m_vhazir[1];
  assign vy_if.istek_hazir   = d_ihazir;
  assign vy_if.veri          = d_veri;
  assign vy_if.veri_gecerli  = d_vgecerli;

  wire [1:0] o_ihazir   = {p1_if.istek_hazir, p0_if.istek_hazir};
  wire [1:0] o_vgecerli = {p1_if.veri_gecerli, p0_if.veri_gecerli};
  wire [BLOK_BIT-1:0] o_veri [2];
  assign o_veri[0] = p0_if.veri;
  assign o_veri[1] = p1_if.veri;

  // stimulus controls (written by the main sequence only)
  int   rate [2];
  int   vh_pct [2];
  int   dn_ih_pct;
  int   dn_max_delay;
  bit   stray_en;
  req_t stim0 [$];
  req_t stim1 [$];
  logic [BLOK_BIT-1:0] dn_data_q [$];

  // reference model and scoreboard
  int   stage;
  logic pref, owner;
  req_t q_req [$];
  logic [BLOK_BIT-1:0] q_resp [$];
  logic grant_log [$];
  logic [1:0] acc_up;
  bit   vy_hs_req, vy_hs_rd, vy_hs_resp;
  int   n_wr, n_rd;
  req_t last_vy;
  logic [BLOK_BIT-1:0] last_resp;
  logic last_resp_port;

  int checks = 0;
  int failures = 0;

  bit pending_rd;
  bit stray;
  int delay;

  task automatic chk(input string nm, input logic [255:0] act, input logic [255:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s act=%0h exp=%0h t=%0t", nm, act, exp, $time);
    end
  endtask

  function automatic bit zar(input int pct);
    return int'($urandom_range(99)) < pct;
  endfunction

  function automatic req_t mk(input logic [ADRES_BIT-1:0] a, input logic y, input logic [BLOK_BIT-1:0] v);
    req_t r;
    r.adres = a;
    r.yaz   = y;
    r.veri  = v;
    return r;
  endfunction

  function automatic logic [BLOK_BIT-1:0] rblok();
    return {$urandom, $urandom, $urandom, $urandom};
  endfunction

  // drivers: update inputs 1 time unit after the active edge
  always @(posedge clk) begin
    req_t r;
    #1;
    if (rst) begin
      for (int p = 0; p < 2; p++) begin
        m_adres[p] = '0;
        m_veri[p]  = '0;
      end
      m_gecerli  = '0;
      m_yaz      = '0;
      m_vhazir   = '0;
      d_ihazir   = 1'b0;
      d_vgecerli = 1'b0;
      d_veri     = '0;
      pending_rd = 1'b0;
      stray      = 1'b0;
      delay      = 0;
    end else begin
      for (int p = 0; p < 2; p++) begin
        if (acc_up[p]) m_gecerli[p] = 1'b0;
        if (!m_gecerli[p] && zar(rate[p])) begin
          if (p == 0 && stim0.size() > 0) begin
            r = stim0.pop_front();
            m_adres[0] = r.adres; m_yaz[0] = r.yaz; m_veri[0] = r.veri; m_gecerli[0] = 1'b1;
          end else if (p == 1 && stim1.size() > 0) begin
            r = stim1.pop_front();
            m_adres[1] = r.adres; m_yaz[1] = r.yaz; m_veri[1] = r.veri; m_gecerli[1] = 1'b1;
          end
        end
        m_vhazir[p] = zar(vh_pct[p]);
      end
      if (stray) begin
        d_vgecerli = 1'b0;
        stray      = 1'b0;
      end
      if (d_vgecerli && vy_hs_resp) d_vgecerli = 1'b0;
      if (vy_hs_req && vy_hs_rd) begin
        pending_rd = 1'b1;
        delay      = int'($urandom_range(dn_max_delay));
      end
      if (pending_rd) begin
        if (delay == 0) begin
          d_veri = (dn_data_q.size() > 0) ? dn_data_q.pop_front() : rblok();
          q_resp.push_back(d_veri);
          d_vgecerli = 1'b1;
          pending_rd = 1'b0;
        end else begin
          delay--;
        end
      end else if (!d_vgecerli && stray_en && stage == 0 && zar(10)) begin
        d_veri     = rblok();
        d_vgecerli = 1'b1;
        stray      = 1'b1;
      end
      d_ihazir = zar(dn_ih_pct);
    end
  end

  // monitor: sample at the falling edge, predict from the arbitration rules, pop the scoreboard
  always @(negedge clk) begin
    int   cur;
    logic [1:0] exp_h;
    logic win;
    req_t r;
    logic [BLOK_BIT-1:0] e;
    acc_up     = '0;
    vy_hs_req  = 1'b0;
    vy_hs_rd   = 1'b0;
    vy_hs_resp = 1'b0;
    if (rst) begin
      chk("reset_out", {o_ihazir, o_vgecerli, vy_if.istek_gecerli, vy_if.istek_yaz, vy_if.veri_hazir,
                        (|vy_if.istek_adres), (|vy_if.istek_veri), (|o_veri[0]), (|o_veri[1])}, '0);
      stage = 0;
      pref  = 1'b0;
      owner = 1'b0;
      q_req.delete();
      q_resp.delete();
      grant_log.delete();
    end else begin
      cur   = stage;
      exp_h = 2'b00;
      win   = 1'b0;
      if (cur == 0 && m_gecerli != 2'b00) begin
        win   = (m_gecerli == 2'b11) ? pref : m_gecerli[1];
        exp_h = win ? 2'b10 : 2'b01;
      end
      chk("istek_hazir", o_ihazir, exp_h);
      acc_up = m_gecerli & o_ihazir;
      if (exp_h != 2'b00) begin
        q_req.push_back(mk(m_adres[win], m_yaz[win], m_veri[win]));
        pref  = ~win;
        owner = win;
        stage = 1;
        grant_log.push_back(win);
      end

      chk("vy_gecerli", vy_if.istek_gecerli, cur == 1);
      vy_hs_req = vy_if.istek_gecerli && d_ihazir;
      vy_hs_rd  = !vy_if.istek_yaz;
      if (cur == 1 && q_req.size() > 0) begin
        chk("vy_payload", {vy_if.istek_adres, vy_if.istek_yaz, vy_if.istek_veri}, q_req[0]);
        if (d_ihazir) begin
          r       = q_req.pop_front();
          last_vy = r;
          if (r.yaz) begin
            stage = 0;
            n_wr++;
          end else begin
            stage = 2;
          end
        end
      end

      chk("vy_veri_hazir", vy_if.veri_hazir, (cur == 2) ? m_vhazir[owner] : 1'b0);
      chk("veri_gecerli", o_vgecerli,
          (cur == 2) ? {owner & d_vgecerli, ~owner & d_vgecerli} : 2'b00);
      if (cur == 2 && d_vgecerli && m_vhazir[owner]) begin
        vy_hs_resp = 1'b1;
        if (q_resp.size() == 0) begin
          chk("resp_extra", 1'b1, 1'b0);
        end else begin
          e = q_resp.pop_front();
          chk("resp_data", o_veri[owner], e);
        end
        last_resp      = o_veri[owner];
        last_resp_port = owner;
        n_rd++;
        stage = 0;
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #4;
  endtask

  task automatic wait_idle(input int budget);
    int n = 0;
    step();
    while (!(stim0.size() == 0 && stim1.size() == 0 && m_gecerli == 2'b00 && stage == 0 &&
             !pending_rd && !d_vgecerli) && n < budget) begin
      step();
      n++;
    end
    chk("idle_timeout", n < budget, 1'b1);
  endtask

  task automatic wait_stage(input int s, input int budget);
    int n = 0;
    while (stage != s && n < budget) begin
      step();
      n++;
    end
    chk("stage_timeout", n < budget, 1'b1);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog act=running exp=finished");
    $fatal(1);
  end

  localparam logic [BLOK_BIT-1:0] DEADBEEF = 128'h0123_4567_89AB_CDEF_0011_2233_DEAD_BEEF;
  localparam logic [BLOK_BIT-1:0] A5_BLOK  = {16{8'hA5}};

  initial begin
    int n, n0, nt;
    rate[0] = 100; rate[1] = 100;
    vh_pct[0] = 100; vh_pct[1] = 100;
    dn_ih_pct = 100; dn_max_delay = 2; stray_en = 1'b0;
    n_wr = 0; n_rd = 0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;

    // single read from port 0
    dn_data_q.push_back(DEADBEEF);
    stim0.push_back(mk(32'h4000_0000, 1'b0, '0));
    wait_idle(100);
    chk("single_read_data", last_resp, DEADBEEF);
    chk("single_read_port", last_resp_port, 1'b0);
    chk("single_read_adres", last_vy.adres, 32'h4000_0000);

    // write from port 1: no response expected
    n0 = n_rd; nt = n_wr;
    stim1.push_back(mk(32'h4000_0040, 1'b1, A5_BLOK));
    wait_idle(100);
    chk("write_req", last_vy, mk(32'h4000_0040, 1'b1, A5_BLOK));
    chk("write_no_resp", n_rd - n0, 0);
    chk("write_count", n_wr - nt, 1);

    // backpressure on both downstream request and upstream response
    dn_ih_pct = 0; dn_max_delay = 0;
    stim0.push_back(mk(32'h4000_0100, 1'b0, '0));
    wait_stage(1, 50);
    for (int i = 0; i < 5; i++) begin
      chk("bp_req_held", {vy_if.istek_gecerli, vy_if.istek_adres}, {1'b1, 32'h4000_0100});
      step();
    end
    vh_pct[0] = 0; dn_ih_pct = 100;
    n = 0;
    while (!(stage == 2 && d_vgecerli) && n < 50) begin
      step();
      n++;
    end
    chk("bp_resp_timeout", n < 50, 1'b1);
    n0 = n_rd;
    for (int i = 0; i < 3; i++) begin
      chk("bp_vhazir_low", {vy_if.veri_hazir, p0_if.veri_gecerli, p1_if.veri_gecerli}, 3'b010);
      step();
    end
    chk("bp_no_early", n_rd - n0, 0);
    vh_pct[0] = 100;
    wait_idle(100);
    chk("bp_single", n_rd - n0, 1);
    dn_max_delay = 2;

    // reset in the middle of a port 1 read
    vh_pct[1] = 0;
    stim1.push_back(mk(32'h4000_0200, 1'b0, '0));
    wait_stage(2, 50);
    repeat (2) @(posedge clk);
    #3 rst = 1'b1;
    repeat (3) @(posedge clk);
    #3 rst = 1'b0;
    vh_pct[1] = 100;

    // contention right after reset: port 0 first
    stim0.push_back(mk(32'h4000_1000, 1'b0, '0));
    stim1.push_back(mk(32'h4000_2000, 1'b0, '0));
    wait_idle(100);
    chk("contention_len", grant_log.size(), 2);
    if (grant_log.size() == 2) begin
      chk("contention_first", grant_log[0], 1'b0);
      chk("contention_second", grant_log[1], 1'b1);
    end

    // both ports streaming reads: strict alternation starting from port 0
    grant_log.delete();
    for (int i = 0; i < 8; i++) begin
      stim0.push_back(mk($urandom, 1'b0, '0));
      stim1.push_back(mk($urandom, 1'b0, '0));
    end
    wait_idle(400);
    chk("alt_len", grant_log.size(), 16);
    for (int i = 0; i < grant_log.size(); i++) begin
      chk("alternation", grant_log[i], 1'((i % 2) == 1));
    end

    // random mix with stray downstream read valids
    rate[0] = 40; rate[1] = 70;
    vh_pct[0] = 70; vh_pct[1] = 60;
    dn_ih_pct = 60; dn_max_delay = 3; stray_en = 1'b1;
    n0 = n_rd + n_wr;
    for (int i = 0; i < 40; i++) begin
      stim0.push_back(mk($urandom, zar(30), rblok()));
      stim1.push_back(mk($urandom, zar(30), rblok()));
    end
    wait_idle(6000);
    chk("random_count", (n_rd + n_wr) - n0, 80);
    chk("random_drained", q_req.size() + q_resp.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
